// File: rtl/prog_clk_divider_pkg.sv
`timescale 1ps/1ps
// Shared constants and types for the programmable multi-channel clock divider.
package prog_clk_div_pkg;

  localparam int unsigned MIN_DIV   = 2;
  // Widest ratio the config request type can carry; DIV_W must not exceed it.
  localparam int unsigned MAX_DIV_W = 16;

  typedef struct packed {
    logic [MAX_DIV_W-1:0] div;
    logic                 en;
  } ch_cfg_t;

  function automatic int unsigned CH_IDX_W(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
`timescale 1ps/1ps
// Valid/ready configuration port of the programmable clock divider.
interface prog_clk_divider_if
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
) ();

  localparam int unsigned CH_W = CH_IDX_W(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_en,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_en,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/prog_clk_divider_channel.sv
`timescale 1ps/1ps
// One 50%-duty divider channel: posedge counter/phase flop, negedge copy for odd
// ratios, and a shadow config that is applied only at the period boundary.
module clk_div_channel #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  input  logic             i_wr_en,
  output logic             o_pending,
  output logic             o_div_out,
  output logic             o_active
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_en;
  logic             r_p;
  logic             r_n;
  logic [DIV_W-1:0] r_sh_div;
  logic             r_sh_en;
  logic             r_pending;

  logic [DIV_W:0]   w_half;
  logic             w_last;
  logic             w_apply;
  logic             w_p_d;

  always_comb begin
    // One extra bit so (N+1) cannot wrap at the largest legal ratio.
    w_half  = ({1'b0, r_div} + (DIV_W+1)'(1)) >> 1;
    w_last  = (r_cnt == r_div - DIV_W'(1));
    w_apply = r_pending & (w_last | ~r_en);
    w_p_d   = r_en & ({1'b0, r_cnt} < w_half);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_en      <= 1'b1;
      r_p       <= 1'b0;
      r_sh_div  <= DIV_W'(DEFAULT_DIV);
      r_sh_en   <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_p <= w_p_d;
      if (w_apply) begin
        r_cnt     <= '0;
        r_div     <= r_sh_div;
        r_en      <= r_sh_en;
        r_pending <= 1'b0;
      end else begin
        r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
        // Writes are only offered while nothing is pending, so they never race an apply.
        if (i_wr) begin
          r_sh_div  <= i_wr_div;
          r_sh_en   <= i_wr_en;
          r_pending <= 1'b1;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_n <= 1'b0;
    end else begin
      r_n <= r_p;
    end
  end

  // p and n change on opposite edges, so the odd-ratio AND cannot glitch.
  assign o_div_out = r_div[0] ? (r_p & r_n) : r_p;
  assign o_active  = r_en;
  assign o_pending = r_pending;

endmodule

// File: rtl/prog_clk_divider.sv
`timescale 1ps/1ps
// Multi-channel programmable clock divider: config decode, ready mux and error
// pulse around NUM_CH independent divider channels.
module prog_clk_divider
  import prog_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  prog_clk_divider_if.slave   cfg,
  output logic [NUM_CH-1:0]   div_out,
  output logic [NUM_CH-1:0]   active
);

  localparam int unsigned CH_W = CH_IDX_W(NUM_CH);
  localparam int unsigned NPAD = 1 << CH_W;

  ch_cfg_t           w_req;
  logic              w_xfer;
  logic              w_bad;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic [NPAD-1:0]   w_pend_pad;
  logic              r_err;

  // Channel indices beyond NUM_CH look permanently busy, so they are never accepted.
  for (genvar i = 0; i < NPAD; i++) begin : g_pad
    if (i < NUM_CH) begin : g_real
      assign w_pend_pad[i] = w_pending[i];
    end else begin : g_none
      assign w_pend_pad[i] = 1'b1;
    end
  end

  always_comb begin
    w_req.div = MAX_DIV_W'(cfg.cfg_div);
    w_req.en  = cfg.cfg_en;
    w_xfer    = cfg.cfg_valid & ~w_pend_pad[cfg.cfg_ch];
    w_bad     = w_req.div < MAX_DIV_W'(MIN_DIV);
  end

  assign cfg.cfg_ready = ~w_pend_pad[cfg.cfg_ch];
  assign cfg.cfg_err   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_xfer & w_bad;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr[i] = w_xfer & ~w_bad & (cfg.cfg_ch == CH_W'(i));

    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (w_wr[i]),
      .i_wr_div  (w_req.div[DIV_W-1:0]),
      .i_wr_en   (w_req.en),
      .o_pending (w_pending[i]),
      .o_div_out (div_out[i]),
      .o_active  (active[i])
    );
  end

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Multi-channel, runtime-programmable clock divider with 50% duty cycle, including odd ratios via dual-edge generation.
Successor to the fixed-ratio divider block: channel count and ratio width are parameters, and ratio and enable are reprogrammable through a valid/ready config port.
Updates are glitch-free and take effect at the channel's period boundary.
Sits beside the reference-clock root and feeds the downstream clock consumers.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
DIV_W, 8, width of the divide ratio; legal ratio range 2..2^DIV_W-1
DEFAULT_DIV, 4, ratio loaded into every channel at reset (must be >=2)

Ports:
clk  in  1  reference clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config can be accepted for cfg_ch
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_div  in  DIV_W  requested ratio N
cfg_en  in  1  requested channel enable
cfg_err  out  1  one-cycle pulse: rejected ratio
div_out  out  NUM_CH  divided clocks
active  out  NUM_CH  channel enabled and running

Behaviour:
- Reset (reset=0, async): every channel cnt=0, p=0, n=0, div=DEFAULT_DIV, en=1, pending=0; div_out=0, active=all-ones, cfg_err=0, cfg_ready=1. Takes effect immediately, including mid-period.
- Per-channel posedge logic:
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - p <= en & (cnt < ceil(N/2)).
- Per-channel negedge flop: n <= p.
- Output: div_out = N even ? p : (p & n).
  - Even N: high N/2 cycles, low N/2 cycles.
  - Odd N: high N/2 cycles (half-cycle resolution), period exactly N clk cycles.
  - p and n switch on opposite edges, so the AND is glitch-free.
- Latency: first div_out rise occurs at the first posedge after reset deasserts (cnt=0 sampled).
- Handshake:
  - cfg_ready = ~pending[cfg_ch].
  - Transfer occurs when cfg_valid & cfg_ready.
  - On transfer with cfg_div<2: cfg_err=1 for the next cycle only; no state change.
  - Otherwise {cfg_div, cfg_en} is written to the shadow register and pending[cfg_ch] is set.
- Apply rules:
  - Running channel (en=1): pending is applied at the posedge where cnt==N-1. div and en load from shadow, cnt restarts at 0, pending clears. The current period always completes, so there are no runt pulses.
  - Disabled channel (en=0): pending is applied at the next posedge.
  - Disable: en=0 forces p=0, so div_out goes low within 1/2 clk. active clears on the apply edge.
  - Re-enable: cnt starts at 0, and the first rise occurs one clk after the apply.
- Simultaneous events:
  - A write accepted in the same cycle as the channel's boundary is not applied at that boundary; it applies at the following boundary.
  - Writes to other channels are unaffected by any one channel's pending state.
- Re-programming the same value is legal. It restarts nothing, and applies at the boundary as a no-op.
- Widths: cnt is DIV_W bits. The half value ceil(N/2) is computed as (N+1)>>1 in DIV_W+1 bits to avoid overflow at N=2^DIV_W-1.

Decomposition:
- Package prog_clk_div_pkg holds:
  - MIN_DIV=2
  - CH_IDX_W function
  - typedef ch_cfg_t {div, en}
- Sub-module clk_div_channel: one divider channel (cnt, p, n flops, shadow/pending, apply logic), instantiated NUM_CH times with generate.
- Top module handles only cfg decode, the cfg_ready mux and cfg_err.

Test Plan:
1. Clock 250ps period; hold reset=0 for 260ps, then set it to 1 -> every div_out period is 1000ps, high 500ps, first rise on the first posedge after release; active=4'b1111.
2. Write ch1 cfg_div=9, cfg_en=1 -> after the current period, ch1 period is 2250ps, high 1125ps (duty 50.0%); transitions land on both clk edges.
3. Write ch0 cfg_div=80 mid-period, then immediately attempt a second write to ch0:
   - cfg_ready=0 for ch0 until the boundary.
   - The old 1000ps period completes with no pulse narrower than 500ps.
   - Afterwards the period is 20000ps, high 10000ps.
4. Write cfg_div=1, then cfg_div=0 -> cfg_err high exactly one cycle after each; ratios unchanged; edge counts over 72000 cycles match the prior ratio.
5. Write ch2 cfg_en=0 -> ch2 low from the boundary and active[2]=0. Then write cfg_div=12, cfg_en=1 -> applied the next cycle; period 3000ps, duty 50%.
6. With ch1 at div=9, drive reset low while div_out[1]=1 -> div_out[1]=0 with no clk edge. After release, ch1 runs at DEFAULT_DIV=4.
